// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: arbitrates two pixel-write requesters onto a single
// registered framebuffer write port and runs a full-frame clear sweep on request.
module fb_write_scheduler #(
    parameter int unsigned H_PIXELS = 320,
    parameter int unsigned V_LINES  = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_start,
    input  logic [7:0]  clear_value,
    output logic        clear_busy,
    output logic        clear_done,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [9:0]  req0_x,
    input  logic [8:0]  req0_y,
    input  logic [7:0]  req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [9:0]  req1_x,
    input  logic [8:0]  req1_y,
    input  logic [7:0]  req1_data,
    output logic [9:0]  fb_x,
    output logic [8:0]  fb_y,
    output logic [7:0]  fb_data,
    output logic        fb_wren,
    output logic [15:0] drop_count
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    localparam logic [9:0] XLast = 10'(H_PIXELS - 1);
    localparam logic [8:0] YLast = 9'(V_LINES - 1);

    logic [0:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;  // 1: requester 1 was granted last
    logic [9:0]  clr_x_q, clr_x_d;
    logic [8:0]  clr_y_q, clr_y_d;
    logic [7:0]  clr_val_q, clr_val_d;
    logic        clear_done_q, clear_done_d;
    logic [9:0]  fb_x_q, fb_x_d;
    logic [8:0]  fb_y_q, fb_y_d;
    logic [7:0]  fb_data_q, fb_data_d;
    logic        fb_wren_q, fb_wren_d;
    logic [15:0] drop_q, drop_d;

    logic        grant0, grant1;
    logic        any_xfer;
    logic [9:0]  sel_x;
    logic [8:0]  sel_y;
    logic [7:0]  sel_data;
    logic        in_range;

    // Round-robin grant; ready is forced low while reset is held so the
    // handshake outputs read 0 during reset like every registered output.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state_q == StIdle)) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign any_xfer   = grant0 | grant1;
    assign sel_x      = grant1 ? req1_x    : req0_x;
    assign sel_y      = grant1 ? req1_y    : req0_y;
    assign sel_data   = grant1 ? req1_data : req0_data;
    assign in_range   = (sel_x <= XLast) && (sel_y <= YLast);

    // Next-state: requester writes and clear entry in IDLE, raster sweep in CLEAR.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        clr_x_d      = clr_x_q;
        clr_y_d      = clr_y_q;
        clr_val_d    = clr_val_q;
        clear_done_d = 1'b0;
        fb_wren_d    = 1'b0;
        fb_x_d       = fb_x_q;
        fb_y_d       = fb_y_q;
        fb_data_d    = fb_data_q;
        drop_d       = drop_q;

        if (state_q == StIdle) begin
            if (any_xfer) begin
                last_grant_d = grant1;
                if (in_range) begin
                    fb_wren_d = 1'b1;
                    fb_x_d    = sel_x;
                    fb_y_d    = sel_y;
                    fb_data_d = sel_data;
                end else if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            // A transfer in this same cycle still completes above.
            if (clear_start) begin
                state_d   = StClear;
                clr_val_d = clear_value;
                clr_x_d   = '0;
                clr_y_d   = '0;
            end
        end else begin
            fb_wren_d = 1'b1;
            fb_x_d    = clr_x_q;
            fb_y_d    = clr_y_q;
            fb_data_d = clr_val_q;
            if (clr_x_q == XLast) begin
                clr_x_d = '0;
                if (clr_y_q == YLast) begin
                    state_d      = StIdle;
                    clear_done_d = 1'b1;
                end else begin
                    clr_y_d = clr_y_q + 9'd1;
                end
            end else begin
                clr_x_d = clr_x_q + 10'd1;
            end
        end
    end

    // State and output registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            clr_x_q      <= '0;
            clr_y_q      <= '0;
            clr_val_q    <= '0;
            clear_done_q <= 1'b0;
            fb_wren_q    <= 1'b0;
            fb_x_q       <= '0;
            fb_y_q       <= '0;
            fb_data_q    <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            clr_x_q      <= clr_x_d;
            clr_y_q      <= clr_y_d;
            clr_val_q    <= clr_val_d;
            clear_done_q <= clear_done_d;
            fb_wren_q    <= fb_wren_d;
            fb_x_q       <= fb_x_d;
            fb_y_q       <= fb_y_d;
            fb_data_q    <= fb_data_d;
            drop_q       <= drop_d;
        end
    end

    assign clear_busy = (state_q == StClear);
    assign clear_done = clear_done_q;
    assign fb_wren    = fb_wren_q;
    assign fb_x       = fb_x_q;
    assign fb_y       = fb_y_q;
    assign fb_data    = fb_data_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler: stimulus pushes expected framebuffer
// writes, a negedge monitor pops and compares every fb_wren cycle.
module tb_fb_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_start;
    logic [7:0]  clear_value;
    logic        clear_busy;
    logic        clear_done;
    logic        req0_valid, req0_ready;
    logic [9:0]  req0_x;
    logic [8:0]  req0_y;
    logic [7:0]  req0_data;
    logic        req1_valid, req1_ready;
    logic [9:0]  req1_x;
    logic [8:0]  req1_y;
    logic [7:0]  req1_data;
    logic [9:0]  fb_x;
    logic [8:0]  fb_y;
    logic [7:0]  fb_data;
    logic        fb_wren;
    logic [15:0] drop_count;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    fb_write_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_start (clear_start),
        .clear_value (clear_value),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req1_data   (req1_data),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_data     (fb_data),
        .fb_wren     (fb_wren),
        .drop_count  (drop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int d);
        wr_t e;
        e.x = 10'(x);
        e.y = 9'(y);
        e.d = 8'(d);
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fb_wren"},    32'(fb_wren),    32'd0);
        chk({tag, "_fb_x"},       32'(fb_x),       32'd0);
        chk({tag, "_fb_y"},       32'(fb_y),       32'd0);
        chk({tag, "_fb_data"},    32'(fb_data),    32'd0);
        chk({tag, "_clear_busy"}, 32'(clear_busy), 32'd0);
        chk({tag, "_clear_done"}, 32'(clear_done), 32'd0);
        chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
        chk({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
        chk({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
    endtask

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        if (fb_wren) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fb_write_unexpected: got (%0d,%0d,%0h), expected no write",
                         fb_x, fb_y, fb_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("fb_write", 32'({fb_x, fb_y, fb_data}), 32'(mon_e));
            end
        end
    end

    int wren_cnt;
    int r1_viol;
    int busy_viol;

    initial begin
        rst_n       = 1'b0;
        clear_start = 1'b0;
        clear_value = 8'h00;
        req0_valid  = 1'b1;
        req0_x      = 10'd5;
        req0_y      = 9'd7;
        req0_data   = 8'hAA;
        req1_valid  = 1'b1;
        req1_x      = 10'd0;
        req1_y      = 9'd0;
        req1_data   = 8'h00;

        // Reset state, including ready gating with valids high.
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");

        // First cycle after release accepts req0 (5,7,AA).
        @(negedge clk);
        rst_n      = 1'b1;
        req1_valid = 1'b0;
        #1;
        chk("single_req0_ready", 32'(req0_ready), 32'd1);
        chk("single_req1_ready", 32'(req1_ready), 32'd0);
        push(5, 7, 8'hAA);

        @(negedge clk);
        chk("single_req0_wren", 32'(fb_wren), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_x     = 10'd100;
        req1_y     = 9'd200;
        req1_data  = 8'h5B;
        #1;
        chk("single_req1_ready", 32'(req1_ready), 32'd1);
        chk("single_req1_r0", 32'(req0_ready), 32'd0);
        push(100, 200, 8'h5B);

        // Contention: last grant was req1, so grants go 0,1,0,1.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_x     = 10'd10;
        req0_y     = 9'd20;
        req0_data  = 8'h11;
        req1_x     = 10'd30;
        req1_y     = 9'd40;
        req1_data  = 8'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("contention_ready0", 32'(req0_ready), 32'((k % 2) == 0));
            chk("contention_ready1", 32'(req1_ready), 32'((k % 2) == 1));
            if ((k % 2) == 0) push(10, 20, 8'h11);
            else              push(30, 40, 8'h22);
            @(negedge clk);
            chk("contention_wren", 32'(fb_wren), 32'd1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Out-of-range drops: x == H_PIXELS, then y == V_LINES.
        @(negedge clk);
        req0_valid = 1'b1;
        req0_x     = 10'd320;
        req0_y     = 9'd0;
        #1 chk("drop_ready_x", 32'(req0_ready), 32'd1);
        @(negedge clk);
        chk("drop_no_wren_x", 32'(fb_wren), 32'd0);
        req0_x = 10'd0;
        req0_y = 9'd240;
        @(negedge clk);
        chk("drop_no_wren_y", 32'(fb_wren), 32'd0);
        chk("drop_count_2", 32'(drop_count), 32'd2);

        // Saturation from a preloaded count.
        force dut.drop_q = 16'hFFFE;
        #1 release dut.drop_q;
        req0_x = 10'd400;
        req0_y = 9'd300;
        @(negedge clk);
        chk("drop_count_ffff", 32'(drop_count), 32'hFFFF);
        @(negedge clk);
        chk("drop_count_sat", 32'(drop_count), 32'hFFFF);
        req0_valid = 1'b0;

        // clear_start together with a req0 transfer: req0 write first, then sweep.
        @(negedge clk);
        req0_valid  = 1'b1;
        req0_x      = 10'd7;
        req0_y      = 9'd3;
        req0_data   = 8'h77;
        clear_start = 1'b1;
        clear_value = 8'h3C;
        #1 chk("clear_req0_ready", 32'(req0_ready), 32'd1);
        push(7, 3, 8'h77);
        for (int y = 0; y < 240; y++)
            for (int x = 0; x < 320; x++)
                push(x, y, 8'h3C);
        wren_cnt  = 0;
        r1_viol   = 0;
        busy_viol = 0;
        for (int k = 1; k <= 76800; k++) begin
            @(negedge clk);
            if (k == 1) begin
                clear_start = 1'b0;
                clear_value = 8'h00;
                req0_valid  = 1'b0;
                req1_valid  = 1'b1;
                req1_x      = 10'd1;
                req1_y      = 9'd2;
                req1_data   = 8'h66;
            end
            if (k == 100) begin
                clear_start = 1'b1;
                clear_value = 8'hEE;
            end
            if (k == 101) clear_start = 1'b0;
            if (fb_wren) wren_cnt++;
            #1;
            if (req1_ready) r1_viol++;
            if (!clear_busy) busy_viol++;
        end
        @(negedge clk);
        if (fb_wren) wren_cnt++;
        chk("clear_wren_cycles", 32'(wren_cnt), 32'd76801);
        chk("clear_req1_blocked", 32'(r1_viol), 32'd0);
        chk("clear_busy_held", 32'(busy_viol), 32'd0);
        chk("clear_done_pulse", 32'(clear_done), 32'd1);
        chk("clear_busy_drop", 32'(clear_busy), 32'd0);
        #1 chk("clear_req1_after", 32'(req1_ready), 32'd1);
        push(1, 2, 8'h66);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("clear_done_one_cycle", 32'(clear_done), 32'd0);
        chk("clear_no_restart", 32'(clear_busy), 32'd0);
        chk("clear_req1_wren", 32'(fb_wren), 32'd1);

        // Reset mid-clear when sweep index 1000 is about to issue.
        @(negedge clk);
        clear_start = 1'b1;
        clear_value = 8'h55;
        for (int i = 0; i < 1000; i++) push(i % 320, i / 320, 8'h55);
        for (int k = 1; k <= 1001; k++) begin
            @(negedge clk);
            if (k == 1) clear_start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midclear");
        repeat (2) begin
            @(negedge clk);
            chk("midclear_no_done", 32'(clear_done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chk("midclear_queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("after_reset_done", 32'(clear_done), 32'd0);
        chk("after_reset_idle", 32'(clear_busy), 32'd0);

        // Fresh clear must restart from (0,0).
        clear_start = 1'b1;
        clear_value = 8'h99;
        for (int i = 0; i < 5; i++) push(i, 0, 8'h99);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                clear_start = 1'b0;
                chk("fresh_clear_busy", 32'(clear_busy), 32'd1);
            end
        end
        #1 rst_n = 1'b0;
        chk("fresh_clear_queue", 32'(exp_q.size()), 32'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
